// File: rtl/uart_rdata_hex_sender_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rdata_hex_sender_pkg                                                  |
// | State encodings and ASCII constants for the read-data hex line sender.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package uart_rdata_hex_sender_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HEX  = 3'd1,
    S_SEP  = 3'd2,
    S_CR   = 3'd3,
    S_LF   = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_LA = 8'h61;
  localparam logic [7:0] CH_UA = 8'h41;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  localparam logic [2:0] LAST_DIGIT = 3'd7;

  // States in which a byte is offered to the TX queue.
  function automatic logic is_char_state(input state_e s);
    return (s == S_HEX) || (s == S_SEP) || (s == S_CR) || (s == S_LF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rdata_hex_sender_nibble_to_ascii.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nibble_to_ascii                                                            |
// | Combinational 4-bit nibble to ASCII hex digit conversion.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nibble_to_ascii
  import uart_rdata_hex_sender_pkg::*;
#(
  parameter bit UPPER_HEX = 1'b0
) (
  input  logic [3:0] nibble_i,
  output logic [7:0] char_o
);

  logic [7:0] w_alpha_base;

  generate
    if (UPPER_HEX) begin : g_upper
      assign w_alpha_base = CH_UA;
    end else begin : g_lower
      assign w_alpha_base = CH_LA;
    end
  endgenerate

  always_comb begin
    if (nibble_i < 4'd10) begin
      char_o = CH_0 + {4'h0, nibble_i};
    end else begin
      char_o = w_alpha_base + {4'h0, nibble_i} - 8'd10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rdata_hex_sender.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rdata_hex_sender                                                      |
// | Serialises a captured 64-bit read-data word pair as an ASCII hex line      |
// | into the UART TX byte queue.                                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_rdata_hex_sender
  import uart_rdata_hex_sender_pkg::*;
#(
  parameter bit UPPER_HEX = 1'b0,
  parameter bit USE_CR    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdata_snd_start_i,
  input  logic [63:0] rdata_snd_i,
  input  logic        pc_print_sel_i,
  input  logic        snd_abort_i,
  input  logic        tx_full_i,
  output logic        tx_wen_o,
  output logic [7:0]  tx_data_o,
  output logic        flushing_wq_o,
  output logic        snd_busy_o,
  output logic        snd_ovf_o
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] data_q, data_d;
  logic        sel_q, sel_d;
  logic        ovf_q, ovf_d;

  logic [31:0] w_word;
  logic [2:0]  w_digit;
  logic [3:0]  w_nibble;
  logic [7:0]  w_hex_char;
  logic        w_wr;
  state_e      w_eol_state;

  // Counter bit 3 selects the word, the low bits walk nibbles MSB first.
  assign w_word   = cnt_q[3] ? data_q[63:32] : data_q[31:0];
  assign w_digit  = cnt_q[2:0];
  assign w_nibble = w_word[{~w_digit, 2'b00} +: 4];

  nibble_to_ascii #(
    .UPPER_HEX (UPPER_HEX)
  ) u_nibble_to_ascii (
    .nibble_i (w_nibble),
    .char_o   (w_hex_char)
  );

  generate
    if (USE_CR) begin : g_eol_crlf
      assign w_eol_state = S_CR;
    end else begin : g_eol_lf
      assign w_eol_state = S_LF;
    end
  endgenerate

  assign w_wr       = is_char_state(state_q) & ~tx_full_i;
  assign tx_wen_o   = w_wr;
  assign snd_busy_o = (state_q != S_IDLE);
  assign snd_ovf_o  = ovf_q;

  always_comb begin
    tx_data_o = 8'h00;
    case (state_q)
      S_HEX:   tx_data_o = w_hex_char;
      S_SEP:   tx_data_o = CH_SP;
      S_CR:    tx_data_o = CH_CR;
      S_LF:    tx_data_o = CH_LF;
      default: tx_data_o = 8'h00;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    sel_d         = sel_q;
    ovf_d         = ovf_q | (rdata_snd_start_i & (state_q != S_IDLE));
    flushing_wq_o = 1'b0;

    if (state_q == S_IDLE) begin
      // Abort takes priority over a simultaneous start.
      if (rdata_snd_start_i && !snd_abort_i) begin
        data_d  = rdata_snd_i;
        sel_d   = pc_print_sel_i;
        cnt_d   = 4'd0;
        state_d = S_HEX;
      end
    end else if (snd_abort_i) begin
      cnt_d   = 4'd0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_HEX: begin
          if (w_wr) begin
            if (w_digit == LAST_DIGIT) begin
              if (!cnt_q[3] && !sel_q) begin
                cnt_d   = cnt_q + 4'd1;
                state_d = S_SEP;
              end else begin
                cnt_d   = 4'd0;
                state_d = w_eol_state;
              end
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        S_SEP: if (w_wr) state_d = S_HEX;
        S_CR:  if (w_wr) state_d = S_LF;
        S_LF:  if (w_wr) state_d = S_DONE;
        S_DONE: begin
          flushing_wq_o = 1'b1;
          state_d       = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      data_q  <= 64'd0;
      sel_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
`default_nettype wire
